mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply/divide unit, one result bit per clock.
// Results land in the HI/LO registers; Start/Busy/Done handshake with divide-by-zero flag.
module mult_div_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic        SIGNED_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic               is_div_reg;
  logic               neg_reg;
  logic               sign_a_reg;
  logic               div_zero_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;

  logic               op_signed, sign_a_in, sign_b_in, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes and signs captured on the accepting edge.
  always_comb begin
    op_signed = SIGNED_EN && !Op[0];
    sign_a_in = op_signed && A[WIDTH-1];
    sign_b_in = op_signed && B[WIDTH-1];
    mag_a     = sign_a_in ? (~A + 1'b1) : A;
    mag_b     = sign_b_in ? (~B + 1'b1) : B;
    b_zero    = (B == '0);
  end

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? opnd_reg : '0)};
    div_shift = {rem_reg[WIDTH-1:0], acc_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    prod_fix  = neg_reg ? (~acc_reg + 1'b1) : acc_reg;
    quo_fix   = neg_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
    rem_fix   = sign_a_reg ? (~rem_reg[WIDTH-1:0] + 1'b1) : rem_reg[WIDTH-1:0];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (Start) state_next = (Op[1] && b_zero) ? DONE : CALC;
      CALC: if (count_reg == CW'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      is_div_reg   <= 1'b0;
      neg_reg      <= 1'b0;
      sign_a_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      rem_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            is_div_reg   <= Op[1];
            neg_reg      <= sign_a_in ^ sign_b_in;
            sign_a_reg   <= sign_a_in;
            div_zero_reg <= Op[1] && b_zero;
            count_reg    <= CW'(WIDTH);
            rem_reg      <= '0;
            // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
            opnd_reg     <= Op[1] ? mag_b : mag_a;
            acc_reg      <= {{WIDTH{1'b0}}, (Op[1] ? mag_a : mag_b)};
          end
        end
        CALC: begin
          count_reg <= count_reg - 1'b1;
          if (is_div_reg) begin
            rem_reg <= div_diff[WIDTH] ? div_shift : div_diff;
            acc_reg <= {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            acc_reg <= {mul_sum, acc_reg[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy    = (state_reg != IDLE);
  assign Done    = (state_reg == DONE);
  assign DivZero = (state_reg == DONE) && div_zero_reg;
  assign Hi      = hi_reg;
  assign Lo      = lo_reg;

endmodule
